// File: rtl/vga_pixel_ctrl.sv
// vga_pixel_ctrl: 640x480@60 raster scheduler with framebuffer fetch and delay-matched sync/blank/index outputs.
// Optional feature macro: SCALE2X_EN (320x240 framebuffer, each pixel shown as a 2x2 block).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   pix_en       pixel strobe; all state advances only when 1
//   fb_rd        framebuffer read strobe, one per fetched pixel
//   fb_addr      framebuffer read address
//   fb_data      palette index returned one pixel tick after fb_rd
//   color_idx    palette index to the colour decoder (BLANK_IDX while blanked)
//   hsync/vsync  active-low sync pulses
//   blank_n      1 during visible pixels
//   frame_start  pulse while the counters sit at (0,0)
module vga_pixel_ctrl #(
    parameter int         H_ACTIVE  = 640,
    parameter int         H_FP      = 16,
    parameter int         H_SYNC    = 96,
    parameter int         H_BP      = 48,
    parameter int         V_ACTIVE  = 480,
    parameter int         V_FP      = 10,
    parameter int         V_SYNC    = 2,
    parameter int         V_BP      = 33,
    parameter int         ADDR_W    = 19,
    parameter logic [3:0] BLANK_IDX = 4'h7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    output logic              fb_rd,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [3:0]        fb_data,
    output logic [3:0]        color_idx,
    output logic              hsync,
    output logic              vsync,
    output logic              blank_n,
    output logic              frame_start
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [ADDR_W-1:0] cur_addr;
    logic              h_last, sof, active, fetch, hs_raw, vs_raw;
    logic              act_q, hs_q, vs_q;
`ifdef SCALE2X_EN
    logic [ADDR_W-1:0] base_q, base_d, cur_base;
`else
    localparam int ADDR_MAX = H_ACTIVE * V_ACTIVE - 1;
    logic [ADDR_W-1:0] addr_q, addr_d;
`endif

    always_comb begin
        h_last = h_q == HW'(H_TOTAL - 1);
        h_d    = h_last ? '0 : h_q + 1'b1;
        v_d    = !h_last ? v_q : (v_q == VW'(V_TOTAL - 1) ? '0 : v_q + 1'b1);
        sof    = h_q == '0 && v_q == '0;
        active = h_q < HW'(H_ACTIVE) && v_q < VW'(V_ACTIVE);
        hs_raw = !(h_q >= HW'(HS_START) && h_q < HW'(HS_END));
        vs_raw = !(v_q >= VW'(VS_START) && v_q < VW'(VS_END));
`ifdef SCALE2X_EN
        // Line base advances only after odd lines so each stored row is shown twice;
        // the last active line does not advance so the address stays in range.
        cur_base = sof ? '0 : base_q;
        cur_addr = cur_base + ADDR_W'(h_q >> 1);
        fetch    = active && !h_q[0];
        base_d   = (h_last && v_q[0] && v_q < VW'(V_ACTIVE - 1)) ? cur_base + ADDR_W'(H_ACTIVE / 2) : cur_base;
`else
        // Running address replaces y*H_ACTIVE+x; it saturates after the last visible pixel.
        cur_addr = sof ? '0 : addr_q;
        fetch    = active;
        addr_d   = (active && cur_addr != ADDR_W'(ADDR_MAX)) ? cur_addr + 1'b1 : cur_addr;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q         <= '0;
            v_q         <= '0;
`ifdef SCALE2X_EN
            base_q      <= '0;
`else
            addr_q      <= '0;
`endif
            frame_start <= 1'b0;
            fb_rd       <= 1'b0;
            fb_addr     <= '0;
            act_q       <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            color_idx   <= BLANK_IDX;
            blank_n     <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
        end else if (pix_en) begin
            h_q         <= h_d;
            v_q         <= v_d;
`ifdef SCALE2X_EN
            base_q      <= base_d;
`else
            addr_q      <= addr_d;
`endif
            frame_start <= sof;
            fb_rd       <= fetch;
            if (fetch)
                fb_addr <= cur_addr;
            act_q       <= active;
            hs_q        <= hs_raw;
            vs_q        <= vs_raw;
            // Without a fresh read (odd column in 2x mode) the previous index is repeated.
            color_idx   <= !act_q ? BLANK_IDX : (fb_rd ? fb_data : color_idx);
            blank_n     <= act_q;
            hsync       <= hs_q;
            vsync       <= vs_q;
        end
    end
endmodule

// File: tb/tb_vga_pixel_ctrl.sv
// tb_vga_pixel_ctrl: directed bench for vga_pixel_ctrl using a reduced raster (30x11 total, 20x6 visible).
module tb_vga_pixel_ctrl;
    localparam int HA = 20, HFP = 2, HSW = 4, HBP = 4;
    localparam int VA = 6, VFP = 1, VSW = 2, VBP = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;
`ifdef SCALE2X_EN
    localparam int LAST_ADDR = (VA / 2) * (HA / 2) - 1;
`else
    localparam int LAST_ADDR = HA * VA - 1;
`endif
    localparam logic [27:0] RST_VEC = {1'b0, 1'b0, 19'd0, 4'h7, 1'b0, 1'b1, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        force_f = 1'b0;
    logic        fb_rd, hsync, vsync, blank_n, frame_start;
    logic [18:0] fb_addr;
    logic [3:0]  fb_data, color_idx;
    int          n_cmp = 0;
    int          n_bad = 0;

    vga_pixel_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .ADDR_W(19), .BLANK_IDX(4'h7)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data(fb_data),
        .color_idx(color_idx), .hsync(hsync), .vsync(vsync),
        .blank_n(blank_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Framebuffer stand-in: returns the low nibble of the address, or 0xF when forced.
    always_comb fb_data = force_f ? 4'hF : fb_addr[3:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int addr_of(input int x, input int y);
`ifdef SCALE2X_EN
        return (y / 2) * (HA / 2) + x / 2;
`else
        return y * HA + x;
`endif
    endfunction

    function automatic logic [27:0] observed();
        return {frame_start, fb_rd, fb_addr, color_idx, blank_n, hsync, vsync};
    endfunction

    // Expected outputs after n pixel ticks since reset release.
    function automatic logic [27:0] model(input int n, input logic frc);
        int p1, x1, y1, p2, x2, y2, ad;
        logic fs, rd, bl, hs, vs;
        logic [3:0] col;
        if (n == 0)
            return RST_VEC;
        p1 = (n - 1) % FT;
        x1 = p1 % HT;
        y1 = p1 / HT;
        fs = p1 == 0;
`ifdef SCALE2X_EN
        rd = x1 < HA && y1 < VA && x1 % 2 == 0;
`else
        rd = x1 < HA && y1 < VA;
`endif
        ad = y1 >= VA ? addr_of(HA - 1, VA - 1) : (x1 >= HA ? addr_of(HA - 1, y1) : addr_of(x1, y1));
        col = 4'h7;
        bl = 1'b0;
        hs = 1'b1;
        vs = 1'b1;
        if (n >= 2) begin
            p2 = (n - 2) % FT;
            x2 = p2 % HT;
            y2 = p2 / HT;
            bl = x2 < HA && y2 < VA;
            col = !bl ? 4'h7 : (frc ? 4'hF : 4'(addr_of(x2, y2)));
            hs = !(x2 >= HA + HFP && x2 < HA + HFP + HSW);
            vs = !(y2 >= VA + VFP && y2 < VA + VFP + VSW);
        end
        return {fs, rd, 19'(ad), col, bl, hs, vs};
    endfunction

    task automatic do_reset();
        pix_en = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int rise1, rise2, fall1, fs_cnt, max_addr;
        logic prev_bl, prev_hs;
        // Reset state
        do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_color", 32'(color_idx), 32'h7);
        check("rst_blank", 32'(blank_n), 32'h0);
        check("rst_hsync", 32'(hsync), 32'h1);
        check("rst_vsync", 32'(vsync), 32'h1);
        check("rst_fs", 32'(frame_start), 32'h0);
        check("rst_fbrd", 32'(fb_rd), 32'h0);
        check("rst_addr", 32'(fb_addr), 32'h0);
        step();
        rst_n = 1'b1;
        // Continuous pix_en over two full frames plus a little
        pix_en = 1'b1;
        rise1 = -1; rise2 = -1; fall1 = -1; fs_cnt = 0; max_addr = 0;
        prev_bl = 1'b0; prev_hs = 1'b1;
        for (int n = 1; n <= 2 * FT + 40; n++) begin
            step();
            check("scan", 32'(observed()), 32'(model(n, 1'b0)));
            if (blank_n && !prev_bl) begin
                if (rise1 < 0) rise1 = n;
                else if (rise2 < 0) rise2 = n;
            end
            if (!hsync && prev_hs && fall1 < 0) fall1 = n;
            if (frame_start) fs_cnt++;
            if (fb_rd && n <= FT && int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
            prev_bl = blank_n;
            prev_hs = hsync;
        end
        check("hs_fall_offset", 32'(fall1 - rise1), 32'(HA + HFP));
        check("line_period", 32'(rise2 - rise1), 32'(HT));
        check("fs_count", 32'(fs_cnt), 32'd3);
        check("last_addr", 32'(max_addr), 32'(LAST_ADDR));
        // Blanking with framebuffer forced to 0xF
        do_reset();
        force_f = 1'b1;
        pix_en = 1'b1;
        for (int n = 1; n <= 2 * HT + 10; n++) begin
            step();
            check("blank_force", 32'(observed()), 32'(model(n, 1'b1)));
        end
        force_f = 1'b0;
        // pix_en on every second cycle: outputs follow ticks and hold in between
        do_reset();
        begin
            int n = 0;
            for (int c = 0; c < 2 * HT + 20; c++) begin
                pix_en = c[0];
                step();
                if (pix_en) n++;
                check("half_rate", 32'(observed()), 32'(model(n, 1'b0)));
            end
        end
        // Mid-frame asynchronous reset at h=10, v=3
        do_reset();
        pix_en = 1'b1;
        for (int n = 1; n <= 3 * HT + 10; n++) begin
            step();
            check("pre_rst", 32'(observed()), 32'(model(n, 1'b0)));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 32'(observed()), 32'(RST_VEC));
        step();
        rst_n = 1'b1;
        for (int n = 1; n <= 3 * HT; n++) begin
            step();
            if (n == 1) check("restart_fs", 32'(frame_start), 32'h1);
            check("post_rst", 32'(observed()), 32'(model(n, 1'b0)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
